// File: rtl/md_collect_pkg.sv
// Shared sizing helpers and word layout for the cell exit collector.
// The FIFO word layout, starting at the LSB:
//   [GRP_W-1:0]                      group index
//   [GRP_W +: LANES*DATA_W]          lane payloads, lane i at i*DATA_W
//   [GRP_W+LANES*DATA_W +: LANES]    lane valids
package md_collect_pkg;

  function automatic int calc_ngroup(input int n_cell, input int lanes);
    return (n_cell + lanes - 1) / lanes;
  endfunction

  function automatic int calc_grp_w(input int ngroup);
    return (ngroup <= 1) ? 1 : $clog2(ngroup);
  endfunction

  function automatic int word_data_lsb(input int grp_w);
    return grp_w;
  endfunction

  function automatic int word_vld_lsb(input int grp_w, input int lanes, input int data_w);
    return grp_w + lanes * data_w;
  endfunction

  function automatic int word_width(input int grp_w, input int lanes, input int data_w);
    return grp_w + lanes * data_w + lanes;
  endfunction

  // Increment modulo n, for group indices that need not be a power of two.
  function automatic int wrap_inc(input int x, input int n);
    return (x + 1 >= n) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/exit_word_fifo.sv
// Synchronous word FIFO with a registered head word.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i/wdata_i  write one word (caller guarantees room, or a pop this cycle)
//   pop_i           consume head word; ignored when head_vld_o is low
//   head_o          registered head word, zero when empty
//   head_vld_o      head word present
//   count_o         words held, including the head
//   full_o          count_o == DEPTH
module exit_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             head_vld_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, count_after_pop;
  logic [WIDTH-1:0] head_q, head_d;
  logic             vld_q;
  logic             pop_eff;

  assign pop_eff = pop_i & vld_q;

  // The head register always mirrors the slot at the read pointer. When the
  // FIFO would otherwise be empty after this cycle's pop, the incoming word
  // bypasses the memory so it is visible one cycle after the push.
  always_comb begin
    rd_ptr_d        = rd_ptr_q + AW'(pop_eff);
    count_after_pop = count_q - CW'(pop_eff);
    count_d         = count_after_pop + CW'(push_i);
    if (count_d == '0)
      head_d = '0;
    else if (count_after_pop == '0)
      head_d = wdata_i;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_i && !rst)
      mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_i);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      vld_q    <= (count_d != '0);
    end
  end

  assign head_o     = head_q;
  assign head_vld_o = vld_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/cell_exit_collector.sv
// Collects entries from N_CELL cell channels, LANES channels per group, into
// a FIFO of group words. A scan pointer picks one group per cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_data        channel c payload at [c*DATA_W +: DATA_W]
//   in_valid       per-channel entry present
//   in_ready       per-channel entry consumed this cycle (combinational)
//   out_data       head word lanes; lane i = channel out_group*LANES+i
//   out_lane_vld   per-lane valid of head word
//   out_group      group index of head word
//   out_valid      head word present
//   out_ready      consumer pops head when out_valid & out_ready
//   count          words held
//   idle           nothing held and nothing offered
module cell_exit_collector
  import md_collect_pkg::*;
#(
  parameter int N_CELL    = 27,
  parameter int DATA_W    = 97,
  parameter int LANES     = 2,
  parameter int DEPTH     = 16,
  parameter int SKIP_IDLE = 1,
  localparam int NGROUP   = calc_ngroup(N_CELL, LANES),
  localparam int GRP_W    = calc_grp_w(NGROUP),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CELL*DATA_W-1:0] in_data,
  input  logic [N_CELL-1:0]        in_valid,
  output logic [N_CELL-1:0]        in_ready,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [LANES-1:0]         out_lane_vld,
  output logic [GRP_W-1:0]         out_group,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     idle
);

  localparam int NPAD     = NGROUP * LANES;
  localparam int WORD_W   = word_width(GRP_W, LANES, DATA_W);
  localparam int DATA_LSB = word_data_lsb(GRP_W);
  localparam int VLD_LSB  = word_vld_lsb(GRP_W, LANES, DATA_W);

  logic [NPAD-1:0]        vld_pad;
  logic [NPAD*DATA_W-1:0] data_pad;
  logic [NGROUP-1:0]      grp_any;
  logic [GRP_W-1:0]       p_q, p_d, sel;
  logic                   found, accept, pop, full;
  logic [LANES-1:0]       lane_vld;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [WORD_W-1:0]      wdata, head;

  // Channels past N_CELL in the last group are padding: never valid, zero data.
  always_comb begin
    vld_pad                     = '0;
    data_pad                    = '0;
    vld_pad[N_CELL-1:0]         = in_valid;
    data_pad[N_CELL*DATA_W-1:0] = in_data;
  end

  always_comb begin
    grp_any = '0;
    for (int g = 0; g < NGROUP; g++)
      grp_any[g] = |vld_pad[g*LANES +: LANES];
  end

  always_comb begin
    int idx;
    idx   = 0;
    sel   = p_q;
    found = 1'b0;
    if (SKIP_IDLE != 0) begin
      // First group with data, searching upward from p and wrapping.
      for (int k = 0; k < NGROUP; k++) begin
        idx = int'(p_q) + k;
        if (idx >= NGROUP)
          idx = idx - NGROUP;
        if (!found && grp_any[idx]) begin
          found = 1'b1;
          sel   = GRP_W'(idx);
        end
      end
    end else begin
      found = grp_any[p_q];
    end
  end

  assign pop    = out_valid & out_ready;
  assign accept = found & (~full | pop) & ~rst;

  assign lane_vld  = vld_pad[int'(sel)*LANES +: LANES];
  assign lane_data = data_pad[int'(sel)*LANES*DATA_W +: LANES*DATA_W];
  assign wdata     = {lane_vld, lane_data, sel};

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < N_CELL; c++)
      in_ready[c] = accept & (int'(sel) == c / LANES) & in_valid[c];
  end

  // Skip mode jumps past the group just taken; fixed rotation only stalls on
  // a group that has data but no room.
  always_comb begin
    if (SKIP_IDLE != 0)
      p_d = accept ? GRP_W'(wrap_inc(int'(sel), NGROUP)) : p_q;
    else
      p_d = (found & ~accept) ? p_q : GRP_W'(wrap_inc(int'(p_q), NGROUP));
  end

  always_ff @(posedge clk) begin
    if (rst)
      p_q <= '0;
    else
      p_q <= p_d;
  end

  exit_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .wdata_i    (wdata),
    .pop_i      (pop),
    .head_o     (head),
    .head_vld_o (out_valid),
    .count_o    (count),
    .full_o     (full)
  );

  assign out_group    = head[GRP_W-1:0];
  assign out_data     = head[DATA_LSB +: LANES*DATA_W];
  assign out_lane_vld = head[VLD_LSB +: LANES];
  assign idle         = (count == '0) & ~(|in_valid);

endmodule

// File: tb/tb_cell_exit_collector.sv
module tb_cell_exit_collector;

  localparam int DW    = 97;
  localparam int MAXC  = 27;
  localparam int MAXL  = 3;
  localparam int DEPTH = 16;
  localparam int NC [3] = '{27, 27, 10};
  localparam int LN [3] = '{2, 2, 3};
  localparam int SK [3] = '{1, 0, 1};
  localparam int NG [3] = '{14, 14, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [MAXC-1:0]    d_valid [3];
  logic [MAXC*DW-1:0] d_data  [3];
  logic               d_rst   [3];
  logic               d_ordy  [3];

  // instance A: defaults, skip mode
  logic [26:0] a_rdy; logic [2*DW-1:0] a_od; logic [1:0] a_lv; logic [3:0] a_grp;
  logic a_ov; logic [4:0] a_cnt; logic a_idle;
  // instance B: defaults, fixed rotation
  logic [26:0] b_rdy; logic [2*DW-1:0] b_od; logic [1:0] b_lv; logic [3:0] b_grp;
  logic b_ov; logic [4:0] b_cnt; logic b_idle;
  // instance C: 10 channels, 3 lanes, skip mode
  logic [9:0] c_rdy; logic [3*DW-1:0] c_od; logic [2:0] c_lv; logic [1:0] c_grp;
  logic c_ov; logic [4:0] c_cnt; logic c_idle;

  cell_exit_collector #(.N_CELL(27), .DATA_W(DW), .LANES(2), .DEPTH(DEPTH), .SKIP_IDLE(1)) u_a (
    .clk(clk), .rst(d_rst[0]), .in_data(d_data[0]), .in_valid(d_valid[0]), .in_ready(a_rdy),
    .out_data(a_od), .out_lane_vld(a_lv), .out_group(a_grp), .out_valid(a_ov),
    .out_ready(d_ordy[0]), .count(a_cnt), .idle(a_idle));

  cell_exit_collector #(.N_CELL(27), .DATA_W(DW), .LANES(2), .DEPTH(DEPTH), .SKIP_IDLE(0)) u_b (
    .clk(clk), .rst(d_rst[1]), .in_data(d_data[1]), .in_valid(d_valid[1]), .in_ready(b_rdy),
    .out_data(b_od), .out_lane_vld(b_lv), .out_group(b_grp), .out_valid(b_ov),
    .out_ready(d_ordy[1]), .count(b_cnt), .idle(b_idle));

  cell_exit_collector #(.N_CELL(10), .DATA_W(DW), .LANES(3), .DEPTH(DEPTH), .SKIP_IDLE(1)) u_c (
    .clk(clk), .rst(d_rst[2]), .in_data(d_data[2][10*DW-1:0]), .in_valid(d_valid[2][9:0]),
    .in_ready(c_rdy), .out_data(c_od), .out_lane_vld(c_lv), .out_group(c_grp), .out_valid(c_ov),
    .out_ready(d_ordy[2]), .count(c_cnt), .idle(c_idle));

  // uniform views of the three instances
  logic [MAXC-1:0]    g_rdy [3];
  logic [MAXL*DW-1:0] g_od  [3];
  logic [MAXL-1:0]    g_lv  [3];
  int                 g_grp [3];
  logic               g_ov  [3];
  int                 g_cnt [3];
  logic               g_idle[3];

  assign g_rdy[0] = a_rdy;  assign g_rdy[1] = b_rdy;  assign g_rdy[2] = {17'b0, c_rdy};
  assign g_od[0]  = {{DW{1'b0}}, a_od}; assign g_od[1] = {{DW{1'b0}}, b_od}; assign g_od[2] = c_od;
  assign g_lv[0]  = {1'b0, a_lv}; assign g_lv[1] = {1'b0, b_lv}; assign g_lv[2] = c_lv;
  assign g_grp[0] = int'(a_grp); assign g_grp[1] = int'(b_grp); assign g_grp[2] = int'(c_grp);
  assign g_ov[0]  = a_ov;  assign g_ov[1] = b_ov;  assign g_ov[2] = c_ov;
  assign g_cnt[0] = int'(a_cnt); assign g_cnt[1] = int'(b_cnt); assign g_cnt[2] = int'(c_cnt);
  assign g_idle[0] = a_idle; assign g_idle[1] = b_idle; assign g_idle[2] = c_idle;

  typedef struct {
    int                 grp;
    logic [MAXL-1:0]    vld;
    logic [MAXL*DW-1:0] data;
  } mword_t;

  mword_t mq [3][$];      // words the collector must be holding, head first
  int mp   [3];           // scan pointer
  int cyc  [3];           // cycles since reset released
  int avail[3][MAXC];     // entries waiting in each upstream channel
  int seqf [3][MAXC];     // sequence number of each channel's front entry
  int expq [3][MAXC];     // next sequence number expected at the output
  int rdy_cnt[3][MAXC];
  int nlog [3];
  int logc [3][64];
  int logg [3][64];
  int logv [3][64];

  function automatic logic [DW-1:0] pay(input int k, input int c, input int s);
    logic [31:0] su, ku, cu;
    su = s; ku = k; cu = c;
    return {su * 32'h9E3779B1, 1'b1, ku[7:0], cu[7:0], su[15:0], ~su};
  endfunction

  task automatic chk(input string nm, input int k, input logic [MAXL*DW-1:0] act,
                     input logic [MAXL*DW-1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp_v);
    end
  endtask

  task automatic chki(input string nm, input int k, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp_v);
    end
  endtask

  // One cycle of the reference behaviour: check what is visible now, then
  // advance the model as the coming rising edge will.
  task automatic model_cycle(input int k);
    logic [MAXC-1:0] exp_rdy;
    bit              any [14];
    bit              found, pop, acc;
    int              sel, ch, g, sz;
    mword_t          w, h;
    exp_rdy = '0;
    for (int c = 0; c < MAXC; c++)
      if (g_rdy[k][c]) rdy_cnt[k][c]++;
    if (d_rst[k]) begin
      chk("in_ready_in_reset", k, g_rdy[k], '0);
      mq[k].delete();
      mp[k] = 0; cyc[k] = 0; nlog[k] = 0;
      for (int c = 0; c < MAXC; c++) expq[k][c] = seqf[k][c];
      return;
    end
    sz = mq[k].size();
    chki("count", k, g_cnt[k], sz);
    chki("out_valid", k, int'(g_ov[k]), int'(sz > 0));
    chki("idle", k, int'(g_idle[k]), int'(sz == 0 && d_valid[k] == '0));
    if (sz > 0) begin
      h = mq[k][0];
      chki("out_group", k, g_grp[k], h.grp);
      chk("out_lane_vld", k, g_lv[k], h.vld);
      chk("out_data", k, g_od[k], h.data);
    end
    pop = (sz > 0) && d_ordy[k];
    for (int gg = 0; gg < NG[k]; gg++) begin
      any[gg] = 1'b0;
      for (int i = 0; i < LN[k]; i++) begin
        ch = gg * LN[k] + i;
        if (ch < NC[k] && d_valid[k][ch]) any[gg] = 1'b1;
      end
    end
    found = 1'b0; sel = mp[k];
    if (SK[k] != 0) begin
      for (int j = 0; j < NG[k]; j++) begin
        g = (mp[k] + j) % NG[k];
        if (!found && any[g]) begin found = 1'b1; sel = g; end
      end
    end else begin
      found = any[mp[k]];
    end
    acc = found && (sz < DEPTH || pop);
    w.grp = sel; w.vld = '0; w.data = '0;
    if (acc) begin
      for (int i = 0; i < LN[k]; i++) begin
        ch = sel * LN[k] + i;
        if (ch < NC[k] && d_valid[k][ch]) begin
          w.vld[i] = 1'b1;
          w.data[i*DW +: DW] = pay(k, ch, seqf[k][ch]);
          exp_rdy[ch] = 1'b1;
        end
      end
    end
    chk("in_ready", k, g_rdy[k], exp_rdy);
    if (pop) begin
      for (int i = 0; i < LN[k]; i++) begin
        if (g_lv[k][i]) begin
          ch = g_grp[k] * LN[k] + i;
          if (ch < NC[k]) begin
            chk("delivered_entry", k, g_od[k][i*DW +: DW], pay(k, ch, expq[k][ch]));
            expq[k][ch]++;
          end else begin
            chki("delivered_channel_range", k, ch, NC[k] - 1);
          end
        end
      end
      void'(mq[k].pop_front());
    end
    if (acc) begin
      mq[k].push_back(w);
      for (int c = 0; c < MAXC; c++)
        if (exp_rdy[c]) begin seqf[k][c]++; avail[k][c]--; end
      if (nlog[k] < 64) begin
        logc[k][nlog[k]] = cyc[k];
        logg[k][nlog[k]] = sel;
        logv[k][nlog[k]] = int'(w.vld);
        nlog[k]++;
      end
    end
    if (SK[k] != 0)
      mp[k] = acc ? (sel + 1) % NG[k] : mp[k];
    else
      mp[k] = (found && !acc) ? mp[k] : (mp[k] + 1) % NG[k];
    cyc[k]++;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) model_cycle(k);
  end

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      d_valid[k] = '0;
      d_data[k]  = '0;
      for (int c = 0; c < NC[k]; c++)
        if (avail[k][c] > 0) begin
          d_valid[k][c] = 1'b1;
          d_data[k][c*DW +: DW] = pay(k, c, seqf[k][c]);
        end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      drive();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      d_rst[k] = 1'b1; d_ordy[k] = 1'b1; mp[k] = 0; cyc[k] = 0; nlog[k] = 0;
      for (int c = 0; c < MAXC; c++) begin
        avail[k][c] = 0; seqf[k][c] = 0; expq[k][c] = 0; rdy_cnt[k][c] = 0;
      end
    end

    // single channel 5 on A (skip mode), single channel 26 on B (rotation)
    avail[0][5]  = 1;
    avail[1][26] = 1;
    step(2);
    for (int k = 0; k < 3; k++) d_rst[k] = 1'b0;
    step(1);
    chki("A_first_out_valid", 0, int'(a_ov), 1);
    chki("A_first_out_group", 0, int'(a_grp), 2);
    chki("A_first_lane_vld", 0, int'(a_lv), 2);
    chki("A_first_count", 0, int'(a_cnt), 1);
    step(19);
    chki("A_ch5_ready_pulses", 0, rdy_cnt[0][5], 1);
    chki("A_push_count", 0, nlog[0], 1);
    chki("A_push_cycle", 0, logc[0][0], 0);
    chki("A_push_group", 0, logg[0][0], 2);
    chki("B_ch26_ready_pulses", 1, rdy_cnt[1][26], 1);
    chki("B_push_count", 1, nlog[1], 1);
    chki("B_push_cycle", 1, logc[1][0], 13);
    chki("B_push_group", 1, logg[1][0], 13);
    chki("B_push_lane_vld", 1, logv[1][0], 1);

    // all channels valid, free-flowing output: 14 back-to-back groups, then wrap
    d_rst[0] = 1'b1;
    for (int c = 0; c < 27; c++) avail[0][c] = 2;
    step(1);
    d_rst[0] = 1'b0;
    step(40);
    chki("A_sweep_pushes", 0, nlog[0], 28);
    for (int i = 0; i < 28; i++) begin
      chki("A_sweep_cycle", 0, logc[0][i], i);
      chki("A_sweep_group", 0, logg[0][i], i % 14);
    end
    chki("A_last_group_lane_vld", 0, logv[0][13], 1);
    chki("A_full_group_lane_vld", 0, logv[0][12], 3);

    // stalled output: fills to 16, then one pop admits exactly one push
    d_rst[0] = 1'b1; d_ordy[0] = 1'b0;
    for (int c = 0; c < 27; c++) avail[0][c] = 3;
    step(1);
    d_rst[0] = 1'b0;
    step(25);
    chki("A_full_count", 0, int'(a_cnt), 16);
    chki("A_full_in_ready", 0, int'(a_rdy), 0);
    chki("A_full_pushes", 0, nlog[0], 16);
    chki("A_full_head_group", 0, int'(a_grp), 0);
    chki("A_16th_group", 0, logg[0][15], 1);
    d_ordy[0] = 1'b1;
    step(1);
    d_ordy[0] = 1'b0;
    step(3);
    chki("A_pop_push_pushes", 0, nlog[0], 17);
    chki("A_pop_push_group", 0, logg[0][16], 2);
    chki("A_pop_push_cycle", 0, logc[0][16], 25);
    chki("A_pop_push_count", 0, int'(a_cnt), 16);
    chki("A_pop_push_head", 0, int'(a_grp), 1);

    // reset with 9 words held; upstream entries collected afresh from p=0
    d_rst[0] = 1'b1;
    for (int c = 0; c < 27; c++) avail[0][c] = 1;
    step(1);
    d_rst[0] = 1'b0;
    step(9);
    chki("A_pre_reset_count", 0, int'(a_cnt), 9);
    d_rst[0] = 1'b1;
    avail[0][0]++;
    step(1);
    d_rst[0] = 1'b0;
    chki("A_post_reset_count", 0, int'(a_cnt), 0);
    chki("A_post_reset_out_valid", 0, int'(a_ov), 0);
    chki("A_post_reset_group", 0, int'(a_grp), 0);
    chki("A_post_reset_lane_vld", 0, int'(a_lv), 0);
    chk("A_post_reset_data", 0, g_od[0], '0);
    d_ordy[0] = 1'b1;
    step(10);
    chki("A_recollect_pushes", 0, nlog[0], 6);
    chki("A_recollect_first_group", 0, logg[0][0], 0);
    chki("A_recollect_first_cycle", 0, logc[0][0], 0);
    chki("A_recollect_second_group", 0, logg[0][1], 9);
    chki("A_recollect_last_group", 0, logg[0][5], 13);
    chki("A_recollect_last_cycle", 0, logc[0][5], 5);

    // random arrivals and back-pressure on B and C
    repeat (10000) begin
      for (int k = 1; k < 3; k++) begin
        for (int c = 0; c < NC[k]; c++)
          if (avail[k][c] < 4 && $urandom_range(7) == 0) avail[k][c]++;
        d_ordy[k] = ($urandom_range(2) != 0);
      end
      step(1);
    end
    d_ordy[1] = 1'b1; d_ordy[2] = 1'b1;
    step(300);
    for (int k = 0; k < 3; k++) begin
      chki("final_count", k, g_cnt[k], 0);
      for (int c = 0; c < NC[k]; c++) begin
        chki("drained_upstream", k, avail[k][c], 0);
        chki("delivered_all", k, expq[k][c], seqf[k][c]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_exit_collector.md
CELL_EXIT_COLLECTOR -- requirements
Module: cell_exit_collector

Interface
REQ-001 Parameter N_CELL, default 27: number of input cell channels.
REQ-002 Parameter DATA_W, default 97: payload bits per channel.
REQ-003 Parameter LANES, default 2: channels captured per FIFO word; NGROUP = ceil(N_CELL/LANES); GRP_W = max(1, clog2(NGROUP)).
REQ-004 Parameter DEPTH, default 16, power of two >= 2: FIFO words.
REQ-005 Parameter SKIP_IDLE, default 1: 1 = scan jumps to the next group with valid data; 0 = fixed one-group-per-cycle rotation.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_data  in  N_CELL*DATA_W  channel c payload at [c*DATA_W +: DATA_W].
REQ-009 in_valid  in  N_CELL  channel c holds an entry.
REQ-010 in_ready  out  N_CELL  combinational; channel c entry consumed this cycle.
REQ-011 out_data  out  LANES*DATA_W  head word; lane i = channel out_group*LANES+i.
REQ-012 out_lane_vld  out  LANES  per-lane valid of head word.
REQ-013 out_group  out  GRP_W  group index of head word.
REQ-014 out_valid  out  1  head word present.
REQ-015 out_ready  in  1  consumer pops head when out_valid & out_ready.
REQ-016 count  out  clog2(DEPTH)+1  words held.
REQ-017 idle  out  1  count==0 and in_valid==0.

Function
REQ-018 Channels >= N_CELL in the last group are padding: valid 0, data 0, in_ready never driven for them.
REQ-019 Scan pointer p (GRP_W bits) names the candidate group; wraps NGROUP-1 -> 0.
REQ-020 SKIP_IDLE=1: selected group g = first group from p upward (wrapping) with any in_valid; none -> no push, p holds.
REQ-021 SKIP_IDLE=0: g = p; p advances by one every cycle except when group p has valid data and cannot push.
REQ-022 accept = (group g has any valid) and (count < DEPTH or pop this cycle).
REQ-023 On accept: one word {lane valids, lane data, g} written; in_ready asserted for exactly the valid channels of g; in SKIP_IDLE=1, p <= g+1 mod NGROUP.
REQ-024 No accept while full without pop: in_ready all 0, p holds, no entry lost or duplicated.
REQ-025 Push-to-out_valid latency 1 cycle; out_* registered FIFO head, stable while out_valid & !out_ready.
REQ-026 Simultaneous push and pop at count==DEPTH: both occur, count stays DEPTH.
REQ-027 Simultaneous push and pop at count==0: word pushed; nothing popped (out_valid was 0); count -> 1.
REQ-028 Pop with out_valid=0 ignored; count never underflows or exceeds DEPTH.
REQ-029 Pointers wrap modulo DEPTH; count = pushes - pops.

Reset
REQ-030 rst high at any clock edge: p=0, FIFO pointers 0, count=0, out_valid=0, out_data/out_lane_vld/out_group=0; in_ready=0 during the reset cycle.
REQ-031 Reset mid-operation discards all held words; first accept possible the cycle after rst deasserts.

Structure
REQ-032 Shared package md_collect_pkg holds NGROUP/GRP_W calculation functions and the word-layout offsets.
REQ-033 One sub-module exit_word_fifo (synchronous, DEPTH x (LANES*(DATA_W+1)+GRP_W), first-word registered output) instantiated once; scan/select logic in the top.

Verification
REQ-034 Default params, only channel 5 valid after reset -> accept in cycle 0, out_group=2, out_lane_vld=2'b10, out_valid cycle 1, in_ready[5] high one cycle.
REQ-035 SKIP_IDLE=1, all 27 valid, out_ready=1 -> groups 0..13 pushed on 14 consecutive cycles, group 13 out_lane_vld=2'b01, then wrap to 0.
REQ-036 SKIP_IDLE=0, only channel 26 valid -> push occurs when p=13, i.e. 13 cycles after reset; every other cycle p increments.
REQ-037 out_ready=0, all valid -> exactly 16 pushes, count=16, in_ready=0 thereafter; raise out_ready one cycle -> one pop and one push, count stays 16.
REQ-038 rst asserted with count=9 -> next cycle count=0, out_valid=0, p=0; held upstream entries re-collected in order without loss.
REQ-039 Random in_valid/out_ready 10k cycles, LANES=3, N_CELL=10 -> scoreboard: every entry delivered exactly once, per-channel order preserved.
